csr_excp_ctrl: RTL and testbench
================================

Name: csr_excp_ctrl

Overview:
- Writeback-side controller and requester of the CSR file. It turns retiring CSR, exception and ERTN instructions into CSR-file transactions: csr_we/num/wmask/wdata, excp_flush, ertn_flush, ecode, esubcode and epc.
- Consumes csr_rdata, era and eentry from the CSR file.
- Drives the register-file write-back for CSR reads, the pipeline flush, and a held front-end redirect handshake.
- Sits between the WB stage and the CSR file.

Parameters:
- PC_RESET, 32'h1c000000, value held on redirect_pc while no redirect has been issued since reset.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- ws_valid  in  1  WB instruction valid
- ws_ready  out  1  controller can accept an instruction
- ws_pc  in  32  PC of the WB instruction
- ws_op  in  4  0 NONE, 1 CSRRD, 2 CSRWR, 3 CSRXCHG, 4 SYSCALL, 5 BREAK, 6 ERTN, 7 INE, 8 LOAD, 9 STORE
- ws_csr_num  in  14  CSR index
- ws_rj_value  in  32  write mask for CSRXCHG
- ws_rd_value  in  32  write data for CSRWR/CSRXCHG
- ws_vaddr  in  32  load/store address
- ws_mem_size  in  2  0 byte, 1 half, 2 word
- ws_adef  in  1  fetch address error flagged upstream
- csr_we  out  1  CSR write enable
- csr_num  out  14  CSR index
- csr_wmask  out  32  CSR write mask
- csr_wdata  out  32  CSR write data
- csr_rdata  in  32  combinational read data
- excp_flush  out  1  exception commit pulse
- ertn_flush  out  1  ERTN commit pulse
- ecode  out  6  exception code
- esubcode  out  3  exception subcode
- epc  out  32  faulting PC
- era  in  32  CSR ERA
- eentry  in  32  CSR EENTRY
- rf_we  out  1  GPR write for a CSR op
- rf_wdata  out  32  old CSR value
- flush_pipe  out  1  kill all younger instructions
- redirect_valid  out  1  new fetch PC valid
- redirect_ready  in  1  fetch accepts the redirect
- redirect_pc  out  32  new fetch PC

Behaviour:
- Reset (resetn low, asynchronous):
  - state IDLE.
  - All outputs 0, except ws_ready=1 and redirect_pc=PC_RESET.
- States IDLE, CSR, FLUSH, REDIR.
- ws_ready = (state==IDLE). Accept = ws_valid & ws_ready. ws_op NONE is accepted and ignored.
- Exception classification at accept, highest priority first:
  - ws_adef: ecode 0x08, esubcode 0.
  - op INE: ecode 0x0D.
  - SYSCALL: ecode 0x0B.
  - BREAK: ecode 0x0C.
  - LOAD/STORE misaligned (half with vaddr[0]=1, or word with vaddr[1:0]!=0): ecode 0x09. Only when EXCP_ALE_CHECK_EN is defined.
  - esubcode is 0 for every ecode.
- IDLE transitions:
  - Exception → FLUSH.
  - ERTN with no exception → FLUSH.
  - CSRRD/CSRWR/CSRXCHG with no exception → CSR.
  - Otherwise stay in IDLE.
- All CSR-file outputs are registered; they are driven during the cycle after accept.
- CSR state, exactly 1 cycle, then IDLE:
  - csr_num = ws_csr_num captured at accept.
  - CSRRD: csr_we=0, wmask=0.
  - CSRWR: csr_we=1, wmask=32'hffffffff, wdata=rd_value.
  - CSRXCHG: csr_we=1, wmask=rj_value, wdata=rd_value.
  - rf_we=1 and rf_wdata=csr_rdata in the same cycle. This returns the pre-write value, because the CSR file updates at the cycle's closing edge.
- FLUSH state, exactly 1 cycle:
  - Exactly one of excp_flush or ertn_flush is 1.
  - ecode, esubcode and epc=ws_pc are valid.
  - flush_pipe=1.
  - csr_we=0.
  - Next state REDIR.
- REDIR state:
  - redirect_valid=1.
  - redirect_pc = eentry after an exception, era after ERTN, both sampled in REDIR.
  - Held stable until redirect_ready. Leave for IDLE on the cycle where redirect_ready=1.
  - redirect_ready may be high on the first REDIR cycle; REDIR then lasts 1 cycle.
  - redirect_pc keeps its last value after leaving REDIR.
- Latency:
  - CSR op: accept at cycle N, write/rf at N+1, next accept at N+2.
  - Exception/ERTN: accept at N, flush at N+1, redirect_valid from N+2.
- All single-cycle pulses (csr_we, rf_we, excp_flush, ertn_flush, flush_pipe) are 0 outside their state.
- Reset mid-operation (any state): return to IDLE immediately. Any pulse in progress is truncated, and redirect_valid drops.
- An instruction presented while ws_ready=0 is not consumed; WB must hold it.

Optional Feature:
- Macro: EXCP_ALE_CHECK_EN.
- Defined: LOAD/STORE alignment is checked and raises ALE (ecode 0x09), with epc=ws_pc.
- Undefined: LOAD/STORE are always treated like NONE and the ALE logic is absent.

Decomposition:
- Shared package/header holds:
  - ws_op encodings.
  - ECODE_ADE=0x08, ECODE_ALE=0x09, ECODE_SYS=0x0B, ECODE_BRK=0x0C, ECODE_INE=0x0D.
  - State encodings.
  - CSR index constants (shared with the CSR file).
- One sub-module, excp_classify: combinational priority encoder from WB fields to {excp, ecode, esubcode}.

Test Plan:
- CSRRD: CSR SAVE0 holds 0x12345678; CSRRD at N → N+1 rf_we=1, rf_wdata=0x12345678, csr_we=0.
- CSRXCHG: CSR SAVE1 holds 0xFFFF0000; mask 0x00FF00FF, data 0xAAAAAAAA → N+1 csr_we=1, wmask=0x00FF00FF, rf_wdata=0xFFFF0000; subsequent read returns 0xFFAA00AA.
- SYSCALL: pc 0x1c000100, eentry 0x1c008000 → N+1 excp_flush=1, ecode 0x0B, epc 0x1c000100; N+2 redirect_valid=1, redirect_pc=0x1c008000; hold 3 cycles with redirect_ready=0, ws_ready=0 throughout.
- ERTN: era 0x1c000104 → N+1 ertn_flush=1, excp_flush=0; N+2 redirect_pc=0x1c000104; redirect_ready=1 immediately → IDLE at N+3.
- Priority: ws_adef=1 with op BREAK → ecode 0x08, not 0x0C. With EXCP_ALE_CHECK_EN: word LOAD at vaddr 0x1c000002 → ecode 0x09. Without the macro: no flush.
- Reset: resetn low during REDIR → redirect_valid=0 and ws_ready=1 immediately, redirect_pc=PC_RESET; after release, the next CSRRD works normally.

Source files
------------

// File: rtl/csr_excp_ctrl_pkg.sv
// Shared definitions for the WB-side CSR/exception controller: op encodings,
// exception codes, controller states and CSR indices shared with the CSR file.
package csr_excp_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE    = 4'd0,
        OP_CSRRD   = 4'd1,
        OP_CSRWR   = 4'd2,
        OP_CSRXCHG = 4'd3,
        OP_SYSCALL = 4'd4,
        OP_BREAK   = 4'd5,
        OP_ERTN    = 4'd6,
        OP_INE     = 4'd7,
        OP_LOAD    = 4'd8,
        OP_STORE   = 4'd9
    } ws_op_e;

    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [2:0] ESUBCODE_NONE = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CSR   = 2'd1,
        S_FLUSH = 2'd2,
        S_REDIR = 2'd3
    } state_e;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [31:0] vaddr);
        logic mis;
        mis = 1'b0;
        if (size == MEM_HALF) begin
            mis = vaddr[0];
        end else if (size == MEM_WORD) begin
            mis = (vaddr[1:0] != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/csr_excp_ctrl_excp_classify.sv
// Combinational exception priority encoder for the retiring WB instruction.
// Load/store alignment checking (ALE) exists only when EXCP_ALE_CHECK_EN is defined.
module excp_classify
    import csr_excp_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic        adef,
    input  logic [31:0] vaddr,
    input  logic [1:0]  mem_size,
    output logic        excp,
    output logic [5:0]  ecode,
    output logic [2:0]  esubcode
);

`ifndef EXCP_ALE_CHECK_EN
    logic unused_ale;
    assign unused_ale = ^{vaddr, mem_size};
`endif

    always_comb begin
        excp     = 1'b1;
        ecode    = '0;
        esubcode = ESUBCODE_NONE;
        if (adef) begin
            ecode = ECODE_ADE;
        end else if (op == OP_INE) begin
            ecode = ECODE_INE;
        end else if (op == OP_SYSCALL) begin
            ecode = ECODE_SYS;
        end else if (op == OP_BREAK) begin
            ecode = ECODE_BRK;
`ifdef EXCP_ALE_CHECK_EN
        end else if ((op == OP_LOAD || op == OP_STORE) && is_misaligned(mem_size, vaddr)) begin
            ecode = ECODE_ALE;
`endif
        end else begin
            excp = 1'b0;
        end
    end

endmodule

// File: rtl/csr_excp_ctrl.sv
// WB-side controller turning retiring CSR/exception/ERTN instructions into CSR-file
// transactions, flushes and a held redirect. Optional macro: EXCP_ALE_CHECK_EN.
module csr_excp_ctrl
    import csr_excp_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic [31:0] ws_pc,
    input  logic [3:0]  ws_op,
    input  logic [13:0] ws_csr_num,
    input  logic [31:0] ws_rj_value,
    input  logic [31:0] ws_rd_value,
    input  logic [31:0] ws_vaddr,
    input  logic [1:0]  ws_mem_size,
    input  logic        ws_adef,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        excp_flush,
    output logic        ertn_flush,
    output logic [5:0]  ecode,
    output logic [2:0]  esubcode,
    output logic [31:0] epc,
    input  logic [31:0] era,
    input  logic [31:0] eentry,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        flush_pipe,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc
);

    state_e      state;
    state_e      state_nxt;

    logic        accept;
    logic        cls_excp;
    logic [5:0]  cls_ecode;
    logic [2:0]  cls_esubcode;
    logic        is_csr_op;
    logic        is_ertn_op;
    logic        take_flush;
    logic        take_csr;
    logic        flush_is_ertn;
    logic [31:0] redir_pc_q;
    logic [31:0] wmask_nxt;
    logic [31:0] wdata_nxt;

    excp_classify u_classify (
        .op       (ws_op),
        .adef     (ws_adef),
        .vaddr    (ws_vaddr),
        .mem_size (ws_mem_size),
        .excp     (cls_excp),
        .ecode    (cls_ecode),
        .esubcode (cls_esubcode)
    );

    assign ws_ready       = (state == S_IDLE);
    assign redirect_valid = (state == S_REDIR);
    assign accept         = ws_valid & ws_ready;

    assign is_csr_op  = (ws_op == OP_CSRRD) || (ws_op == OP_CSRWR) || (ws_op == OP_CSRXCHG);
    assign is_ertn_op = (ws_op == OP_ERTN);
    assign take_flush = accept & (cls_excp | is_ertn_op);
    assign take_csr   = accept & ~cls_excp & is_csr_op;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take_flush) begin
                    state_nxt = S_FLUSH;
                end else if (take_csr) begin
                    state_nxt = S_CSR;
                end
            end
            S_CSR:   state_nxt = S_IDLE;
            S_FLUSH: state_nxt = S_REDIR;
            S_REDIR: begin
                if (redirect_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wmask_nxt = '0;
        wdata_nxt = '0;
        case (ws_op)
            OP_CSRWR: begin
                wmask_nxt = '1;
                wdata_nxt = ws_rd_value;
            end
            OP_CSRXCHG: begin
                wmask_nxt = ws_rj_value;
                wdata_nxt = ws_rd_value;
            end
            default: ;
        endcase
    end

    // Every pulse is set only by the accept that enters its state, so it lasts one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csr_we        <= 1'b0;
            csr_num       <= '0;
            csr_wmask     <= '0;
            csr_wdata     <= '0;
            rf_we         <= 1'b0;
            excp_flush    <= 1'b0;
            ertn_flush    <= 1'b0;
            flush_pipe    <= 1'b0;
            ecode         <= '0;
            esubcode      <= '0;
            epc           <= '0;
            flush_is_ertn <= 1'b0;
            redir_pc_q    <= PC_RESET;
        end else begin
            csr_we     <= take_csr & (ws_op != OP_CSRRD);
            rf_we      <= take_csr;
            excp_flush <= take_flush & cls_excp;
            ertn_flush <= take_flush & ~cls_excp;
            flush_pipe <= take_flush;
            if (take_csr) begin
                csr_num   <= ws_csr_num;
                csr_wmask <= wmask_nxt;
                csr_wdata <= wdata_nxt;
            end
            if (take_flush) begin
                ecode         <= cls_excp ? cls_ecode : '0;
                esubcode      <= cls_esubcode;
                epc           <= ws_pc;
                flush_is_ertn <= ~cls_excp;
            end
            if (state == S_REDIR) begin
                redir_pc_q <= redirect_pc;
            end
        end
    end

    // Target follows the CSR file live while redirecting, then the last value is held.
    assign redirect_pc = (state == S_REDIR) ? (flush_is_ertn ? era : eentry) : redir_pc_q;

    // csr_rdata is read before the closing-edge write, so this is the pre-write value.
    assign rf_wdata = rf_we ? csr_rdata : '0;

endmodule

// File: tb/tb_csr_excp_ctrl.sv
// Self-checking bench for csr_excp_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference model of the CSR file and exception rules.
module tb_csr_excp_ctrl;
    import csr_excp_ctrl_pkg::*;

    localparam logic [31:0] PC_RST = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid;
    logic        ws_ready;
    logic [31:0] ws_pc;
    logic [3:0]  ws_op;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_rj_value;
    logic [31:0] ws_rd_value;
    logic [31:0] ws_vaddr;
    logic [1:0]  ws_mem_size;
    logic        ws_adef;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic [5:0]  ecode;
    logic [2:0]  esubcode;
    logic [31:0] epc;
    logic [31:0] era;
    logic [31:0] eentry;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        flush_pipe;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    // CSR file environment (written by the DUT) and the reference copy (written by the model)
    logic [31:0] env_mem [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic [31:0] exp_rpc;

    always #5 clk = ~clk;

    csr_excp_ctrl #(.PC_RESET(PC_RST)) dut (
        .clk(clk), .resetn(resetn), .ws_valid(ws_valid), .ws_ready(ws_ready),
        .ws_pc(ws_pc), .ws_op(ws_op), .ws_csr_num(ws_csr_num), .ws_rj_value(ws_rj_value),
        .ws_rd_value(ws_rd_value), .ws_vaddr(ws_vaddr), .ws_mem_size(ws_mem_size),
        .ws_adef(ws_adef), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .excp_flush(excp_flush),
        .ertn_flush(ertn_flush), .ecode(ecode), .esubcode(esubcode), .epc(epc),
        .era(era), .eentry(eentry), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .flush_pipe(flush_pipe), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
    );

    assign csr_rdata = env_mem[csr_num];
    assign era       = env_mem[CSR_ERA];
    assign eentry    = env_mem[CSR_EENTRY];

    always @(posedge clk) begin
        if (csr_we) begin
            env_mem[csr_num] <= (env_mem[csr_num] & ~csr_wmask) | (csr_wdata & csr_wmask);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_instr(input logic [3:0] op, input logic [13:0] num,
                            input logic [31:0] rj, input logic [31:0] rd,
                            input logic [31:0] pc, input logic [31:0] vaddr,
                            input logic [1:0] size, input logic adef,
                            input int unsigned hold);
        logic        exc;
        logic        ertn;
        logic        csrop;
        logic [5:0]  ec;
        logic [31:0] old;
        logic [31:0] mask;
        logic [31:0] tgt;
        int unsigned sz;
        int unsigned low;

        sz  = size;
        low = vaddr % 4;
        exc = 1'b1;
        if (adef)                  ec = 6'h08;
        else if (op == 4'd7)       ec = 6'h0D;
        else if (op == 4'd4)       ec = 6'h0B;
        else if (op == 4'd5)       ec = 6'h0C;
`ifdef EXCP_ALE_CHECK_EN
        else if ((op == 4'd8 || op == 4'd9) &&
                 ((sz == 1 && (low % 2) != 0) || (sz == 2 && low != 0))) ec = 6'h09;
`endif
        else begin
            exc = 1'b0;
            ec  = 6'h00;
        end
        ertn  = !exc && op == 4'd6;
        csrop = !exc && op >= 4'd1 && op <= 4'd3;

        @(negedge clk);
        check("ready_idle", {31'b0, ws_ready}, 32'd1);
        ws_valid = 1'b1; ws_op = op; ws_csr_num = num; ws_rj_value = rj;
        ws_rd_value = rd; ws_pc = pc; ws_vaddr = vaddr; ws_mem_size = size; ws_adef = adef;

        @(negedge clk);
        check("ready_busy", {31'b0, ws_ready}, {31'b0, !(exc || ertn || csrop)});
        check("rf_we", {31'b0, rf_we}, {31'b0, csrop});
        check("excp_flush", {31'b0, excp_flush}, {31'b0, exc});
        check("ertn_flush", {31'b0, ertn_flush}, {31'b0, ertn});
        check("flush_pipe", {31'b0, flush_pipe}, {31'b0, exc || ertn});
        check("csr_we", {31'b0, csr_we}, {31'b0, csrop && op != 4'd1});
        check("rdir_idle", {31'b0, redirect_valid}, 32'd0);
        if (csrop) begin
            old  = ref_mem[num];
            mask = (op == 4'd1) ? 32'h0 : (op == 4'd2) ? 32'hffffffff : rj;
            check("csr_num", {18'b0, csr_num}, {18'b0, num});
            check("csr_wmask", csr_wmask, mask);
            if (op != 4'd1) check("csr_wdata", csr_wdata, rd);
            check("rf_wdata", rf_wdata, old);
            ref_mem[num] = (old & ~mask) | (rd & mask);
        end else begin
            check("rf_wdata0", rf_wdata, 32'd0);
        end
        if (exc || ertn) begin
            if (exc) check("ecode", {26'b0, ecode}, {26'b0, ec});
            check("esubcode", {29'b0, esubcode}, 32'd0);
            check("epc", epc, pc);
            ws_valid = 1'($urandom_range(0, 1));
            ws_op    = 4'($urandom_range(0, 9));
            ws_pc    = $urandom;
            tgt      = exc ? ref_mem[CSR_EENTRY] : ref_mem[CSR_ERA];
            exp_rpc  = tgt;
            for (int unsigned i = 0; i <= hold; i++) begin
                @(negedge clk);
                check("rdir_valid", {31'b0, redirect_valid}, 32'd1);
                check("rdir_pc", redirect_pc, tgt);
                check("ready_redir", {31'b0, ws_ready}, 32'd0);
                check("pulse_off", {29'b0, flush_pipe, excp_flush, ertn_flush}, 32'd0);
            end
            redirect_ready = 1'b1;
            ws_valid = 1'b0;
            @(negedge clk);
            redirect_ready = 1'b0;
            check("rdir_done", {31'b0, redirect_valid}, 32'd0);
            check("rdir_hold", redirect_pc, exp_rpc);
            check("ready_back", {31'b0, ws_ready}, 32'd1);
        end else if (csrop) begin
            ws_valid = 1'($urandom_range(0, 1));
            ws_op    = 4'($urandom_range(0, 9));
        end else begin
            ws_valid = 1'b0;
            check("rdir_pc_keep", redirect_pc, exp_rpc);
        end
        ws_valid = (exc || ertn || !csrop) ? 1'b0 : ws_valid;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] nums [6];
        logic [3:0]  rop;

        nums[0] = CSR_SAVE0; nums[1] = CSR_SAVE1; nums[2] = CSR_SAVE2;
        nums[3] = CSR_SAVE3; nums[4] = CSR_ERA;   nums[5] = CSR_EENTRY;
        resetn = 1'b0; ws_valid = 1'b0; ws_pc = '0; ws_op = '0; ws_csr_num = '0;
        ws_rj_value = '0; ws_rd_value = '0; ws_vaddr = '0; ws_mem_size = '0;
        ws_adef = 1'b0; redirect_ready = 1'b0; exp_rpc = PC_RST;

        #12;
        check("rst_ready", {31'b0, ws_ready}, 32'd1);
        check("rst_rpc", redirect_pc, PC_RST);
        check("rst_pulses", {26'b0, csr_we, rf_we, excp_flush, ertn_flush, flush_pipe, redirect_valid}, 32'd0);
        check("rst_regs", {12'b0, csr_num, ecode}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // preload the CSR file through the controller
        do_instr(OP_CSRWR, CSR_SAVE0, 0, 32'h12345678, 0, 0, 0, 0, 0);
        do_instr(OP_CSRWR, CSR_SAVE1, 0, 32'hFFFF0000, 0, 0, 0, 0, 0);
        do_instr(OP_CSRWR, CSR_SAVE2, 0, 32'h0BADF00D, 0, 0, 0, 0, 0);
        do_instr(OP_CSRWR, CSR_SAVE3, 0, 32'h00C0FFEE, 0, 0, 0, 0, 0);
        do_instr(OP_CSRWR, CSR_EENTRY, 0, 32'h1c008000, 0, 0, 0, 0, 0);
        do_instr(OP_CSRWR, CSR_ERA, 0, 32'h1c000104, 0, 0, 0, 0, 0);

        do_instr(OP_CSRRD, CSR_SAVE0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        do_instr(OP_CSRXCHG, CSR_SAVE1, 32'h00FF00FF, 32'hAAAAAAAA, 0, 0, 0, 0, 0);
        do_instr(OP_CSRRD, CSR_SAVE1, 0, 0, 0, 0, 0, 0, 0);
        check("xchg_result", ref_mem[CSR_SAVE1], 32'hFFAA00AA);
        do_instr(OP_SYSCALL, 0, 0, 0, 32'h1c000100, 0, 0, 0, 3);
        do_instr(OP_ERTN, 0, 0, 0, 32'h1c000200, 0, 0, 0, 0);
        do_instr(OP_BREAK, 0, 0, 0, 32'h1c000300, 0, 0, 1'b1, 1);
        do_instr(OP_LOAD, 0, 0, 0, 32'h1c000400, 32'h1c000002, MEM_WORD, 0, 1);
        do_instr(OP_STORE, 0, 0, 0, 32'h1c000404, 32'h1c000001, MEM_HALF, 0, 0);
        do_instr(OP_LOAD, 0, 0, 0, 32'h1c000408, 32'h1c000003, MEM_BYTE, 0, 0);
        do_instr(OP_NONE, CSR_SAVE2, 0, 0, 0, 0, 0, 0, 0);

        // asynchronous reset while redirecting
        @(negedge clk);
        ws_valid = 1'b1; ws_op = OP_SYSCALL; ws_pc = 32'h1c000500; ws_adef = 1'b0;
        @(negedge clk);
        ws_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_redir", {31'b0, redirect_valid}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("midrst_valid", {31'b0, redirect_valid}, 32'd0);
        check("midrst_ready", {31'b0, ws_ready}, 32'd1);
        check("midrst_rpc", redirect_pc, PC_RST);
        exp_rpc = PC_RST;
        @(negedge clk);
        resetn = 1'b1;
        do_instr(OP_CSRRD, CSR_SAVE0, 0, 0, 0, 0, 0, 0, 0);

        for (int unsigned t = 0; t < 300; t++) begin
            rop = 4'($urandom_range(0, 9));
            do_instr(rop, nums[$urandom_range(0, 5)], $urandom, $urandom, $urandom,
                     $urandom, 2'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0),
                     $urandom_range(0, 3));
        end

        for (int i = 0; i < 6; i++) begin
            check("csr_file", env_mem[nums[i]], ref_mem[nums[i]]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
